// File: rtl/xbus_sched_pkg.sv
// Shared types for the X-bus stream scheduler: FSM states, flush length and
// the per-pass configuration latched at start.
package xbus_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLUSH,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } sched_state_t;

  localparam int unsigned FLUSH_CYCLES = 2;
  localparam int unsigned CFG_W        = 8;

  typedef struct packed {
    logic [CFG_W-1:0] kernel_size;
    logic [CFG_W-1:0] rows;
    logic [CFG_W-1:0] cols;
    logic [CFG_W-1:0] tag;
  } sched_cfg_t;

  function automatic logic cfg_invalid(input sched_cfg_t c,
                                       input int unsigned max_rows,
                                       input int unsigned max_cols);
    return (c.kernel_size == '0) || (c.rows == '0) || (c.cols == '0) ||
           (32'(c.rows) > max_rows) || (32'(c.cols) > max_cols);
  endfunction

endpackage

// File: rtl/xbus_idx_counter.sv
// Nested k/x/y walk over one pass: k innermost, then column, then row.
module xbus_idx_counter
  import xbus_sched_pkg::*;
#(
  parameter int unsigned NUM_ROW = 4,
  parameter int unsigned NUM_COL = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       clear,
  input  logic                       advance,
  input  logic [CFG_W-1:0]           kernel_size,
  input  logic [CFG_W-1:0]           rows,
  input  logic [CFG_W-1:0]           cols,
  output logic [$clog2(NUM_ROW)-1:0] y,
  output logic [$clog2(NUM_COL)-1:0] x,
  output logic                       last
);

  localparam logic [CFG_W-1:0] ONE = CFG_W'(1);

  logic [CFG_W-1:0] k_q, x_q, y_q;
  logic             k_last, x_last, y_last;

  always_comb begin
    k_last = (k_q == kernel_size - ONE);
    x_last = (x_q == cols - ONE);
    y_last = (y_q == rows - ONE);
    last   = k_last && x_last && y_last;
  end

  always_ff @(posedge clk) begin
    if (!rstn || clear) begin
      k_q <= '0;
      x_q <= '0;
      y_q <= '0;
    end else if (advance) begin
      if (k_last) begin
        k_q <= '0;
        if (x_last) begin
          x_q <= '0;
          y_q <= y_last ? '0 : y_q + ONE;
        end else begin
          x_q <= x_q + ONE;
        end
      end else begin
        k_q <= k_q + ONE;
      end
    end
  end

  assign y = y_q[$clog2(NUM_ROW)-1:0];
  assign x = x_q[$clog2(NUM_COL)-1:0];

endmodule

// File: rtl/xbus_stream_scheduler.sv
// Sequences one convolution pass onto the PE-array X-bus: flush/config
// phase, then the token stream through a single registered valid/ready stage.
module xbus_stream_scheduler
  import xbus_sched_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_COL    = 4,
  parameter int unsigned NUM_ROW    = 4
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         start,
  input  logic                         abort,
  input  logic [7:0]                   kernel_size,
  input  logic [$clog2(NUM_ROW):0]     cfg_rows,
  input  logic [$clog2(NUM_COL):0]     cfg_cols,
  input  logic [$clog2(NUM_ROW)-1:0]   cfg_tag,
  input  logic                         src_valid,
  output logic                         src_ready,
  input  logic [DATA_WIDTH-1:0]        src_ifmap,
  input  logic [DATA_WIDTH-1:0]        src_fltr,
  input  logic [2*DATA_WIDTH-1:0]      src_psum,
  output logic                         flush,
  output logic                         rst_busy,
  output logic [$clog2(NUM_ROW)-1:0]   y_tag,
  output logic                         bus_valid,
  input  logic                         bus_ready,
  output logic [DATA_WIDTH-1:0]        bus_ifmap,
  output logic [DATA_WIDTH-1:0]        bus_fltr,
  output logic [2*DATA_WIDTH-1:0]      bus_psum,
  output logic [$clog2(NUM_ROW)-1:0]   y_id,
  output logic [$clog2(NUM_COL)-1:0]   x_id,
  output logic                         done,
  output logic                         cfg_err
);

  localparam int unsigned YW = $clog2(NUM_ROW);
  localparam int unsigned XW = $clog2(NUM_COL);
  localparam logic [1:0]  FLUSH_LAST = 2'(FLUSH_CYCLES - 1);

  sched_state_t   state_q, state_d;
  logic [1:0]     flush_cnt_q;
  sched_cfg_t     cfg_q, cfg_in;
  logic           cfg_bad;
  logic           err_q;
  logic           accept, drain_hs;
  logic           cnt_last, cnt_clear;
  logic [YW-1:0]  cnt_y;
  logic [XW-1:0]  cnt_x;

  always_comb begin
    cfg_in.kernel_size = kernel_size;
    cfg_in.rows        = CFG_W'(cfg_rows);
    cfg_in.cols        = CFG_W'(cfg_cols);
    cfg_in.tag         = CFG_W'(cfg_tag);
    cfg_bad            = cfg_invalid(cfg_in, NUM_ROW, NUM_COL);
  end

  assign accept   = src_valid && src_ready;
  assign drain_hs = bus_valid && bus_ready;

  always_comb begin
    state_d   = state_q;
    src_ready = 1'b0;
    case (state_q)
      S_IDLE:   if (start) state_d = cfg_bad ? S_DONE : S_FLUSH;
      S_FLUSH:  if (flush_cnt_q == FLUSH_LAST) state_d = S_STREAM;
      S_STREAM: begin
        src_ready = !bus_valid || bus_ready;
        if (src_valid && src_ready && cnt_last) state_d = S_DRAIN;
      end
      S_DRAIN:  if (drain_hs) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (abort) state_d = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      flush_cnt_q <= '0;
      cfg_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= (state_q == S_FLUSH && !abort) ? flush_cnt_q + 2'd1 : '0;
      if (abort) begin
        cfg_q <= '0;
        err_q <= 1'b0;
      end else if (state_q == S_IDLE && start) begin
        // A rejected pass keeps the config cleared; only the error flag is held into DONE.
        cfg_q <= cfg_bad ? '0 : cfg_in;
        err_q <= cfg_bad;
      end else if (state_q == S_DONE) begin
        cfg_q <= '0;
        err_q <= 1'b0;
      end
    end
  end

  assign flush    = (state_q == S_FLUSH);
  assign rst_busy = (state_q == S_FLUSH);
  assign done     = (state_q == S_DONE);
  assign cfg_err  = (state_q == S_DONE) && err_q;
  assign y_tag    = (state_q != S_IDLE) ? cfg_q.tag[YW-1:0] : '0;

  assign cnt_clear = abort || (state_q != S_STREAM);

  xbus_idx_counter #(
    .NUM_ROW (NUM_ROW),
    .NUM_COL (NUM_COL)
  ) u_idx (
    .clk         (clk),
    .rstn        (rstn),
    .clear       (cnt_clear),
    .advance     (accept),
    .kernel_size (cfg_q.kernel_size),
    .rows        (cfg_q.rows),
    .cols        (cfg_q.cols),
    .y           (cnt_y),
    .x           (cnt_x),
    .last        (cnt_last)
  );

  // Load wins over drain so a simultaneous drain+load keeps full throughput.
  always_ff @(posedge clk) begin
    if (!rstn || abort) begin
      bus_valid <= 1'b0;
      bus_ifmap <= '0;
      bus_fltr  <= '0;
      bus_psum  <= '0;
      y_id      <= '0;
      x_id      <= '0;
    end else if (accept) begin
      bus_valid <= 1'b1;
      bus_ifmap <= src_ifmap;
      bus_fltr  <= src_fltr;
      bus_psum  <= src_psum;
      y_id      <= cnt_y;
      x_id      <= cnt_x;
    end else if (drain_hs) begin
      bus_valid <= 1'b0;
    end
  end

endmodule
